nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle wide adder controller that drives the team's 4-bit ripple-carry adder (`fourBitAdder`) one nibble per clock. It accepts wide operands on a start pulse and feeds the adder one nibble at a time, least significant first. It registers each nibble sum, chains the carry through a flop, and presents the full-width sum and carry with a one-cycle done pulse. It sits directly upstream of the 4-bit adder, supplies its operands and carry-in, and consumes its sum and carry-out.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  W  operand A, latched on accepted start.
- b  in  W  operand B, latched on accepted start.
- cin  in  1  carry-in to nibble 0, latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  W  result; holds until the next accepted start.
- cout  out  1  carry out of the top nibble; held like sum.
- add_a  out  4  operand-A nibble to the 4-bit adder.
- add_b  out  4  operand-B nibble to the 4-bit adder.
- add_cin  out  1  carry into the 4-bit adder.
- add_s  in  4  sum nibble from the 4-bit adder, combinational.
- add_cout  in  1  carry from the 4-bit adder, combinational.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - On start=1: latch a, b and cin; idx<=0; carry_reg<=cin; clear sum; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - add_a = a_reg[4*idx+:4]; add_b = b_reg[4*idx+:4]; add_cin = carry_reg.
  - Each edge: sum[4*idx+:4]<=add_s; carry_reg<=add_cout; idx<=idx+1.
  - On the edge where idx==NIBBLES-1: cout<=add_cout; go to DONE.
  - start is ignored throughout RUN.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1, accept it as in IDLE and go straight to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Outside RUN: add_a, add_b and add_cin are driven to 0.
- Arithmetic: the result is {cout,sum} = a + b + cin, modulo 2^(W+1). There is no saturation.
- The idx counter is ceil(log2(NIBBLES)) bits wide and does not wrap during RUN.
- Reset behaviour, effective immediately at any point including mid-RUN:
  - Outputs: busy=0, done=0, sum=0, cout=0, add_a=0, add_b=0, add_cin=0 (ovf=0 when compiled in).
  - Internal: a_reg, b_reg, carry_reg and idx are cleared to 0; state returns to IDLE.
  - The partial result is discarded.

## Timing
- start is sampled at edge E0.
- RUN occupies the cycles after edges E0..E(NIBBLES-1); nibble k is presented in the cycle after edge Ek.
- sum, cout and done=1 are visible after edge E(NIBBLES); latency is NIBBLES+1 cycles from start to done.
- Throughput with back-to-back starts: one result per NIBBLES+1 cycles.
- busy rises after E0 and falls after E(NIBBLES).
- The adder path is combinational within one cycle: add_* out -> fourBitAdder -> add_s/add_cout in.
- sum bits change only on RUN edges; the upper nibbles of a new operation read 0 until written.

## Configuration
- NIBBLE_SERIAL_ADDER_OVF_EN defined:
  - Adds output `ovf  out  1`: signed two's-complement overflow.
  - ovf = (a_reg[W-1]==b_reg[W-1]) && (final sum[W-1]!=a_reg[W-1]).
  - Registered with cout; reset 0; cleared on accepted start.
  - cin participates in the add but does not enter the ovf formula.
- Not defined: no ovf port and no related logic.

## Test plan
All scenarios use NIBBLES=4 with the adder model connected.
- a=0x0000, b=0xFFFF, cin=0 -> after 5 cycles: done pulse, sum=0xFFFF, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; add_cin observed as 0,1,1,1 across RUN cycles.
- a=0x5A5A, b=0xA5A5, cin=1 -> sum=0x0000, cout=1.
  - Immediately followed by start with a=0x1234, b=0x1111, cin=0 in the DONE cycle -> accepted with no IDLE cycle; sum=0x2345, cout=0.
- start pulsed in RUN cycle 2 with different operands -> ignored; first result is unchanged and exactly one done pulse occurs.
- rst asserted asynchronously in RUN cycle 3 -> immediately busy=0, sum=0, cout=0, state IDLE; no done pulse; a subsequent start completes normally.
- With NIBBLE_SERIAL_ADDER_OVF_EN:
  - a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0.
  - a=0x8000, b=0x8000, cin=0 -> sum=0x0000, ovf=1, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: drives an external 4-bit ripple adder one nibble per clock to add wide operands
// Parameter: NIBBLES - number of 4-bit slices (2..16); operand width W = 4*NIBBLES.
// Ports:
//   clk, rst (async active-high)
//   start, a[W], b[W], cin  - request and operands, taken in IDLE or DONE
//   busy, done, sum[W], cout - status and held result
//   add_a, add_b, add_cin   - nibble operands and carry to the 4-bit adder
//   add_s, add_cout         - combinational nibble result from the 4-bit adder
// Option: define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                   ovf
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state, state_nx;
    logic [W-1:0]   a_reg, b_reg;
    logic           carry_reg;
    logic [IW-1:0]  idx;
    logic           accept, last;
    always_comb begin
        accept   = start && (state != RUN);
        last     = idx == IW'(NIBBLES - 1);
        state_nx = accept ? RUN : (state == RUN && !last) ? RUN : (state == RUN) ? DONE : IDLE;
        busy     = state == RUN;
        done     = state == DONE;
        add_a    = busy ? a_reg[4*idx +: 4] : 4'd0;
        add_b    = busy ? b_reg[4*idx +: 4] : 4'd0;
        add_cin  = busy && carry_reg;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                idx       <= '0;
                sum       <= '0;
                cout      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                ovf       <= 1'b0;
`endif
            end else if (busy) begin
                sum[4*idx +: 4] <= add_s;
                carry_reg       <= add_cout;
                // parks at 0 on the final nibble so idx never wraps when NIBBLES is a power of two
                idx             <= last ? '0 : idx + 1'b1;
                if (last) begin
                    cout <= add_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    // add_s[3] is the final sum MSB, written on this same edge
                    ovf  <= (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized and directed checks of nibble_serial_adder against a whole-word arithmetic model
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;
    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, done, cout, add_cin, add_cout;
    logic [W-1:0]  sum;
    logic [3:0]    add_a, add_b, add_s;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic          ovf;
`endif
    int            tests = 0, fails = 0, lat = 0;
    logic          cins[$];

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    always #5 clk = ~clk;

    always @(negedge clk) if (busy) cins.push_back(add_cin);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; cin = c; start = 1'b1;
        cins.delete();
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
    endtask

    task automatic wait_done();
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic finish_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint unsigned xa, ya, ex, m, e;
        xa = x; ya = y;
        ex = xa + ya + c;
        wait_done();
        check("latency", lat, N + 1);
        check("sum", sum, ex & ((64'd1 << W) - 1));
        check("cout", cout, (ex >> W) & 1);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("ovf", ovf, (x[W-1] == y[W-1]) && (((ex >> (W - 1)) & 1) != x[W-1]));
`endif
        check("cin_count", cins.size(), N);
        for (int k = 0; k < N && k < cins.size(); k++) begin
            m = (64'd1 << (4 * k)) - 1;
            e = ((xa & m) + (ya & m) + c) >> (4 * k);
            check($sformatf("add_cin%0d", k), cins[k], e & 1);
        end
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        start_op(x, y, c);
        finish_op(x, y, c);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_add", {add_a, add_b, add_cin}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_op(16'h0000, 16'hFFFF, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("idle_add", {add_a, add_b, add_cin}, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0);
        do_op(16'h5A5A, 16'hA5A5, 1'b1);
        start_op(16'h1234, 16'h1111, 1'b0);
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        finish_op(16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #1;
        start_op(16'h1357, 16'h2468, 1'b1);
        check("sum_clr", sum, 0);
        @(posedge clk); #1; lat++;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1; lat++;
        start = 1'b0;
        finish_op(16'h1357, 16'h2468, 1'b1);
        @(posedge clk); #1;
        check("one_done", done, 0);
        check("ign_busy", busy, 0);
        start_op(16'hABCD, 16'h1234, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_sum", sum, 0);
        check("arst_cout", cout, 0);
        check("arst_add", {add_a, add_b, add_cin}, 0);
        @(posedge clk); #1;
        check("arst_hold", {busy, done}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("arst_nodone", {busy, done}, 0);
        do_op(16'hABCD, 16'h1234, 1'b0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        do_op(16'h7FFF, 16'h0001, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0);
`endif
        repeat (25) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
